fcfs_pci_arbiter: RTL and testbench

//   First-come-first-served arbiter for a PCI-style shared bus with N_MASTERS masters.

---
 rtl/fcfs_pci_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_fcfs_pci_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fcfs_pci_arbiter.sv
// ---------------------------------------------------------------------------
// fcfs_pci_arbiter
//   First-come-first-served arbiter for a PCI-style shared bus. Requesting
//   masters are appended to a FIFO in arrival order. The head of the FIFO is
//   granted. Ownership passes on when the head starts a transaction (FRAME#
//   asserted on an idle bus) or drops its request. A one-cycle all-ones
//   turnaround (GAP) always separates two grants.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     When defined, a grant that stays unused on an idle bus for
//     TIMEOUT_CYCLES cycles is revoked. The head is then rotated to the tail.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req        active-low bus requests, one per master
//   frame      active-low PCI FRAME#
//   irdy       active-low PCI IRDY#
//   gnt        active-low registered grants, at most one bit low
//   gnt_valid  high while a grant bit is low
//   gnt_idx    index of the granted master (0 when gnt_valid=0)
//   q_count    number of queued masters, including the granted head
// ---------------------------------------------------------------------------
module fcfs_pci_arbiter #(
  parameter int N_MASTERS      = 8,
  parameter int IDX_W          = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 frame,
  input  logic                 irdy,
  output logic [N_MASTERS-1:0] gnt,
  output logic                 gnt_valid,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic [IDX_W:0]       q_count
);

  if (IDX_W != $clog2(N_MASTERS)) begin : g_bad_idx_w
    $error("IDX_W must equal clog2(N_MASTERS)");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t               state, state_nx;
  logic [IDX_W-1:0]     q    [N_MASTERS];
  logic [IDX_W-1:0]     q_nx [N_MASTERS];
  logic [IDX_W:0]       cnt, cnt_nx;
  logic [N_MASTERS-1:0] in_q, in_q_nx;
  logic [N_MASTERS-1:0] head_onehot;
  logic [IDX_W-1:0]     head;
  logic                 bus_idle_q;
  logic                 start;
  logic                 pop;
  logic                 rotate;
  logic                 timeout;

  assign head    = q[0];
  assign start   = ~frame & bus_idle_q;
  assign q_count = cnt;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  // Counts idle-bus cycles of an unused grant; clears whenever GRANT is left.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state != GRANT || state_nx != GRANT) begin
      tcnt <= '0;
    end else if (bus_idle_q) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign timeout = (tcnt == TW'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  // Queue update: pop the head first, then drop withdrawn entries, then append
  // new requesters in ascending index order. Appending uses the registered
  // in_q map, so a master popped at this edge re-enters at the tail next edge.
  always_comb begin
    logic [IDX_W:0] n;
    state_nx = state;
    pop      = 1'b0;
    rotate   = 1'b0;
    in_q_nx  = in_q;
    n        = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      q_nx[i] = '0;
    end

    if (state == GRANT) begin
      if (start) begin
        pop = 1'b1;
      end else if (req[head]) begin
        pop = 1'b1;
      end else if (timeout) begin
        rotate = 1'b1;
      end
    end

    for (int j = 0; j < N_MASTERS; j++) begin
      if (j < int'(cnt)) begin
        // The granted head is governed by pop/rotate, not by withdraw.
        if (j == 0 && state == GRANT) begin
          if (pop) begin
            in_q_nx[q[0]] = 1'b0;
          end else if (!rotate) begin
            q_nx[n[IDX_W-1:0]] = q[0];
            n = n + (IDX_W+1)'(1);
          end
        end else if (req[q[j]]) begin
          in_q_nx[q[j]] = 1'b0;
        end else begin
          q_nx[n[IDX_W-1:0]] = q[j];
          n = n + (IDX_W+1)'(1);
        end
      end
    end

    if (rotate) begin
      q_nx[n[IDX_W-1:0]] = q[0];
      n = n + (IDX_W+1)'(1);
    end

    for (int i = 0; i < N_MASTERS; i++) begin
      if (!req[i] && !in_q[i]) begin
        q_nx[n[IDX_W-1:0]] = IDX_W'(i);
        n = n + (IDX_W+1)'(1);
        in_q_nx[i] = 1'b1;
      end
    end
    cnt_nx = n;

    case (state)
      IDLE:    if (n != '0) state_nx = GRANT;
      GRANT:   if (pop || rotate) state_nx = GAP;
      GAP:     state_nx = (n != '0) ? GRANT : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    head_onehot       = '0;
    head_onehot[head] = 1'b1;
  end

  // State register; grant outputs are registered from the current state, so
  // they trail a state change by one cycle and GAP shows all ones once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      in_q       <= '0;
      bus_idle_q <= 1'b1;
      gnt        <= '1;
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        q[i] <= '0;
      end
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      in_q       <= in_q_nx;
      bus_idle_q <= frame & irdy;
      gnt        <= (state == GRANT) ? ~head_onehot : '1;
      gnt_valid  <= (state == GRANT);
      gnt_idx    <= (state == GRANT) ? head : '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        q[i] <= q_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_fcfs_pci_arbiter.sv
module tb_fcfs_pci_arbiter;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         frame;
  logic         irdy;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [W-1:0] gnt_idx;
  logic [W:0]   q_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int sb[$];
  logic prev_valid = 1'b0;

  fcfs_pci_arbiter #(.N_MASTERS(N), .IDX_W(W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .frame(frame), .irdy(irdy),
    .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every new grant (rising gnt_valid) must match the next
  // expected master in arrival order.
  always @(negedge clk) begin
    if (gnt_valid === 1'b1 && prev_valid !== 1'b1) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        int e;
        logic [N-1:0] exp_gnt;
        e = sb.pop_front();
        exp_gnt = ~(N'(1) << e);
        check("sb_gnt_idx", 32'(gnt_idx), 32'(e));
        check("sb_gnt_bits", 32'(gnt), 32'(exp_gnt));
      end
    end
    prev_valid = gnt_valid;
  end

  initial begin
    rst = 1'b1; req = '1; frame = 1'b1; irdy = 1'b1;
    repeat (2) tick();
    check("rst_gnt", 32'(gnt), 32'hFF);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    check("rst_qcount", 32'(q_count), 32'd0);
    rst = 1'b0;
    tick();

    // single master, start, re-queue while req still low
    req[2] = 1'b0; sb.push_back(2);
    tick();
    check("t1_gnt_enq_edge", 32'(gnt), 32'hFF);
    check("t1_qcount_enq", 32'(q_count), 32'd1);
    tick();
    check("t1_gnt_granted", 32'(gnt), 32'hFB);
    check("t1_idx", 32'(gnt_idx), 32'd2);
    tick();
    frame = 1'b0;
    tick();
    check("t1_qcount_pop", 32'(q_count), 32'd0);
    frame = 1'b1; sb.push_back(2);
    tick();
    check("t1_gnt_gap", 32'(gnt), 32'hFF);
    check("t1_qcount_requeue", 32'(q_count), 32'd1);
    req[2] = 1'b1;
    repeat (3) tick();
    check("t1_idle_valid", 32'(gnt_valid), 32'd0);
    check("t1_idle_qcount", 32'(q_count), 32'd0);

    // arrival order
    req[5] = 1'b0; sb.push_back(5);
    repeat (2) tick();
    check("t2_gnt5", 32'(gnt), 32'hDF);
    req[1] = 1'b0; sb.push_back(1);
    tick();
    check("t2_qcount2", 32'(q_count), 32'd2);
    frame = 1'b0; req[5] = 1'b1;
    tick();
    check("t2_qcount_pop", 32'(q_count), 32'd1);
    check("t2_gnt_held", 32'(gnt), 32'hDF);
    frame = 1'b1;
    tick();
    check("t2_gap", 32'(gnt), 32'hFF);
    tick();
    check("t2_gnt1", 32'(gnt), 32'hFD);
    req[1] = 1'b1;
    repeat (3) tick();
    check("t2_idle", 32'(gnt_valid), 32'd0);

    // simultaneous requests: ascending index order
    req[0] = 1'b0; req[1] = 1'b0; sb.push_back(0); sb.push_back(1);
    repeat (2) tick();
    check("t3_gnt0", 32'(gnt), 32'hFE);
    frame = 1'b0; req[0] = 1'b1;
    tick();
    frame = 1'b1;
    tick();
    check("t3_gap", 32'(gnt), 32'hFF);
    tick();
    check("t3_idx1", 32'(gnt_idx), 32'd1);
    req[1] = 1'b1;
    repeat (3) tick();
    check("t3_idle", 32'(q_count), 32'd0);

    // withdraw from the middle of the queue
    req[3] = 1'b0; sb.push_back(3);
    repeat (2) tick();
    check("t4_gnt3", 32'(gnt), 32'hF7);
    req[4] = 1'b0; req[6] = 1'b0; sb.push_back(6);
    tick();
    check("t4_qcount3", 32'(q_count), 32'd3);
    req[4] = 1'b1;
    tick();
    check("t4_qcount_withdraw", 32'(q_count), 32'd2);
    check("t4_gnt3_kept", 32'(gnt), 32'hF7);
    frame = 1'b0; req[3] = 1'b1;
    tick();
    frame = 1'b1;
    repeat (2) tick();
    check("t4_gnt6", 32'(gnt), 32'hBF);
    req[6] = 1'b1;
    repeat (3) tick();
    check("t4_idle", 32'(gnt_valid), 32'd0);

    // reset in the middle of a grant
    req[3] = 1'b0; sb.push_back(3);
    repeat (2) tick();
    check("t5_gnt3", 32'(gnt), 32'hF7);
    rst = 1'b1;
    tick();
    check("t5_rst_gnt", 32'(gnt), 32'hFF);
    check("t5_rst_qcount", 32'(q_count), 32'd0);
    check("t5_rst_valid", 32'(gnt_valid), 32'd0);
    rst = 1'b0; sb.push_back(3);
    tick();
    check("t5_requeue_qcount", 32'(q_count), 32'd1);
    check("t5_gnt_not_yet", 32'(gnt), 32'hFF);
    tick();
    check("t5_gnt3_again", 32'(gnt), 32'hF7);
    req[3] = 1'b1;
    repeat (3) tick();
    check("t5_idle", 32'(gnt_valid), 32'd0);

`ifdef ARB_TIMEOUT_EN
    // unused grant is revoked and the head rotates behind master 7
    req[2] = 1'b0; req[7] = 1'b0; sb.push_back(2); sb.push_back(7);
    repeat (2) tick();
    check("t6_gnt2", 32'(gnt), 32'hFB);
    for (int i = 0; i < 40 && gnt_valid; i++) tick();
    check("t6_revoked", 32'(gnt_valid), 32'd0);
    for (int i = 0; i < 5 && !gnt_valid; i++) tick();
    check("t6_gnt7", 32'(gnt), 32'h7F);
    check("t6_qcount", 32'(q_count), 32'd2);
    req[7] = 1'b1; sb.push_back(2);
    for (int i = 0; i < 6 && gnt !== 8'hFB; i++) tick();
    check("t6_gnt2_after", 32'(gnt), 32'hFB);
    req[2] = 1'b1;
    repeat (3) tick();
    check("t6_idle", 32'(gnt_valid), 32'd0);
`else
    // without the timeout an unused grant is held indefinitely
    req[2] = 1'b0; sb.push_back(2);
    repeat (2) tick();
    repeat (30) tick();
    check("t6_held_gnt", 32'(gnt), 32'hFB);
    check("t6_held_qcount", 32'(q_count), 32'd1);
    req[2] = 1'b1;
    repeat (3) tick();
    check("t6_idle", 32'(gnt_valid), 32'd0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
